// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: issues req/ack accesses, stalls the
// upstream pipeline while an access is outstanding and reports access errors.
module mem_access_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [DATA_W-1:0] ADDR_in,
  input  logic [DATA_W-1:0] WD_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] RD_out,
  output logic              stall_out,
  output logic              bubble_out,
  output logic              err_out
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              stall;
  logic              valid_acc, bad_acc;

  // Misalignment only matters when an access is actually requested.
  assign valid_acc = (MemRead_in ^ MemWrite_in) & (ADDR_in[1:0] == 2'b00);
  assign bad_acc   = (MemRead_in & MemWrite_in) |
                     ((MemRead_in | MemWrite_in) & (ADDR_in[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_acc) begin
          stall   = 1'b1;
          addr_d  = ADDR_in;
          wdata_d = WD_in;
          we_d    = MemWrite_in;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = StWait;
        end else if (bad_acc) begin
          err_d = 1'b1;
        end
      end
      StWait: begin
        stall = 1'b1;
        // Ack wins over expiry when both land in the same cycle.
        if (mem_ack) begin
          if (!we_q) rd_d = mem_rdata;
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          req_d   = 1'b0;
          rd_d    = '0;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign RD_out     = rd_q;
  assign err_out    = err_q;
  assign stall_out  = stall;
  assign bubble_out = stall;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM stage of the MIPS-lite pipeline against a variable-latency memory that uses a req/ack handshake. It holds the upstream pipeline with a stall while an access is outstanding. It inserts bubbles into the MEM/WB register during the stall and delivers the read data to MEM/WB once the access completes. It flags misaligned accesses, conflicting controls and memory timeouts.

Parameters:
DATA_W, 32, data and address width
TIMEOUT, 255, max cycles in WAIT without mem_ack before abort (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
MemRead_in  in  1  load request from the EX/MEM register
MemWrite_in  in  1  store request from the EX/MEM register
ADDR_in  in  DATA_W  byte address from the EX/MEM register
WD_in  in  DATA_W  store data from the EX/MEM register
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, registered, valid while mem_req
mem_addr  out  DATA_W  latched address, registered
mem_wdata  out  DATA_W  latched store data, registered
mem_ack  in  1  single-cycle completion pulse from memory
mem_rdata  in  DATA_W  read data, valid with mem_ack
RD_out  out  DATA_W  read data to MEM/WB RD_in, registered
stall_out  out  1  hold PC, IF/ID, ID/EX and EX/MEM; combinational
bubble_out  out  1  MEM/WB loads a nop (RegWrite_in gated to 0); equals stall_out
err_out  out  1  one-cycle error pulse, registered

Behaviour:
- Reset values: state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, RD_out=0, err_out=0, timeout counter=0. rst at any time, including mid-access, returns to IDLE at that edge and drops mem_req. There is no pending-ack tracking: a late ack after reset is ignored.
- A valid access requires exactly one of MemRead_in/MemWrite_in high and ADDR_in[1:0]==0.
- States:
  - IDLE:
    - Valid access: stall_out=1. Latch ADDR_in→mem_addr, WD_in→mem_wdata, MemWrite_in→mem_we, and set mem_req=1 at the edge. Go to WAIT and clear the counter.
    - Misaligned address, or both MemRead_in and MemWrite_in high: no request, no stall; err_out=1 in the next cycle; stay in IDLE.
    - Otherwise: stall_out=0.
  - WAIT:
    - stall_out=1 and mem_req held at 1.
    - mem_ack=1: if the access is a read, RD_out<=mem_rdata; mem_req<=0; go to DONE.
    - No ack and counter==TIMEOUT-1: mem_req<=0, RD_out<=0, err_out<=1; go to DONE.
    - Otherwise: increment the counter.
    - An ack arriving in the same cycle as expiry counts as an ack, not a timeout.
  - DONE:
    - stall_out=0, so the pipeline advances and MEM/WB captures RD_out. MemRead_in/MemWrite_in are ignored here because they still belong to the completed instruction.
    - Go to IDLE unconditionally.
- Latency with a zero-wait memory (ack in the first WAIT cycle): 2 stall cycles; RD_out is valid in the DONE cycle. In general, stall cycles = 1 + number of WAIT cycles up to and including the ack.
- mem_ack in IDLE or DONE is spurious: ignore it, leave RD_out unchanged, no error.
- Stores leave RD_out unchanged.
- mem_addr and mem_wdata stay stable for the whole of WAIT regardless of input changes.
- err_out is high for exactly one cycle per error event.
- Timeout counter is 8 bits and never wraps: leaving WAIT clears it.

Test Plan:
1. Load: ADDR_in=0x10, MemRead_in=1; ack one cycle after mem_req rises with mem_rdata=0xDEADBEEF → stall_out high 2 cycles, mem_we=0, mem_addr=0x10; RD_out=0xDEADBEEF in DONE; stall_out=0 in DONE.
2. Store with 3-cycle memory: ADDR_in=0x20, WD_in=0x12345678, MemWrite_in=1; ack on the 3rd WAIT cycle → mem_we=1, mem_wdata stable at 0x12345678 through WAIT, 4 stall cycles, RD_out unchanged, bubble_out==stall_out on every cycle.
3. Misaligned or conflicting: ADDR_in=0x22 with MemRead_in=1, then MemRead_in=MemWrite_in=1 → mem_req never asserted, stall_out=0, err_out pulses once per case.
4. Timeout: TIMEOUT=4, load with no ack → mem_req high exactly 4 cycles, then err_out=1 for one cycle, RD_out=0, controller back in IDLE two cycles later. Also drive ack on the 4th WAIT cycle → treated as success, no err_out.
5. Reset mid-access: assert rst in the 2nd WAIT cycle, then drive ack after reset → mem_req=0 and all outputs at reset values at the edge; late ack causes no RD_out change.
6. Back-to-back loads: two consecutive load instructions, zero-wait memory → second access starts in the cycle after DONE, DONE cycle does not re-trigger, exactly 2 mem_req pulses and 2 correct RD_out values.
